alu_share_arbiter: RTL and testbench

Shares the single MainALU instance between `NREQ` requesters (e.g. execute stage, branch-compare unit, address generator) with round-robin arbitration and valid/ready handshakes on both request and response sides. The selected operation is registered into an issue stage that drives the ALU. The ALU's combinational outputs are captured one cycle later into a response register that is tagged with the requester index. The block sits between the requesters and the ALU and owns every ALU input.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/alu_share_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, datapath widths and the issued-operation record.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int CTRL_W  = 4;

    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b1010;
    localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1011;
    localparam logic [CTRL_W-1:0] ALU_IDLE = 4'b1111;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [CTRL_W-1:0]  ctrl;
        logic [SHAMT_W-1:0] shamt;
    } alu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // Scan offsets from highest to lowest so the smallest offset from ptr is written last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_idx = IW'(idx);
                any     = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign gnt[gi] = any && (gnt_idx == IW'(gi));
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin accept into an issue register,
// ALU outputs captured into a tagged response register one cycle later.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_a,
    input  logic [NREQ*DATA_W-1:0]    req_b,
    input  logic [NREQ*CTRL_W-1:0]    req_ctrl,
    input  logic [NREQ*SHAMT_W-1:0]   req_shamt,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [CTRL_W-1:0]         alu_ctrl,
    output logic [SHAMT_W-1:0]        alu_shamt,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_overflow,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_overflow
);

    alu_op_t             req_ops [NREQ];
    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                any;

    logic [IDW-1:0]      rr_ptr_reg;
    logic                iss_v_reg;
    alu_op_t             iss_op_reg;
    logic [IDW-1:0]      iss_id_reg;
    logic                rsp_v_reg;
    logic [DATA_W-1:0]   rsp_result_reg;
    logic                rsp_zero_reg;
    logic                rsp_overflow_reg;
    logic [IDW-1:0]      rsp_id_reg;

    logic                rsp_fire;
    logic                rsp_free;
    logic                iss_adv;
    logic                iss_free;
    logic                accept;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_ops[gi] = '{
            a:     req_a[gi*DATA_W +: DATA_W],
            b:     req_b[gi*DATA_W +: DATA_W],
            ctrl:  req_ctrl[gi*CTRL_W +: CTRL_W],
            shamt: req_shamt[gi*SHAMT_W +: SHAMT_W]
        };
    end

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Ready is derived from valid and pipeline state only, never from ready itself.
    assign rsp_fire  = rsp_v_reg & rsp_ready[rsp_id_reg];
    assign rsp_free  = ~rsp_v_reg | rsp_fire;
    assign iss_adv   = iss_v_reg & rsp_free;
    assign iss_free  = ~iss_v_reg | iss_adv;
    assign accept    = any & iss_free & ~rst;
    assign req_ready = accept ? gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            iss_v_reg  <= 1'b0;
            iss_op_reg <= '0;
            iss_id_reg <= '0;
        end else begin
            if (accept) begin
                iss_v_reg  <= 1'b1;
                iss_op_reg <= req_ops[gnt_idx];
                iss_id_reg <= gnt_idx;
                rr_ptr_reg <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end else if (iss_adv) begin
                iss_v_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v_reg        <= 1'b0;
            rsp_result_reg   <= '0;
            rsp_zero_reg     <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            rsp_id_reg       <= '0;
        end else begin
            if (iss_adv) begin
                rsp_v_reg        <= 1'b1;
                rsp_result_reg   <= alu_result;
                rsp_zero_reg     <= alu_zero;
                rsp_overflow_reg <= alu_overflow;
                rsp_id_reg       <= iss_id_reg;
            end else if (rsp_fire) begin
                rsp_v_reg <= 1'b0;
            end
        end
    end

    assign alu_a     = iss_op_reg.a;
    assign alu_b     = iss_op_reg.b;
    assign alu_shamt = iss_op_reg.shamt;
    assign alu_ctrl  = iss_v_reg ? iss_op_reg.ctrl : ALU_IDLE;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp_valid
        assign rsp_valid[gi] = rsp_v_reg && (rsp_id_reg == IDW'(gi));
    end

    assign rsp_id       = rsp_id_reg;
    assign rsp_result   = rsp_result_reg;
    assign rsp_zero     = rsp_zero_reg;
    assign rsp_overflow = rsp_overflow_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural MainALU and a response scoreboard.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              ovf;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*DATA_W-1:0]  req_a;
    logic [NREQ*DATA_W-1:0]  req_b;
    logic [NREQ*CTRL_W-1:0]  req_ctrl;
    logic [NREQ*SHAMT_W-1:0] req_shamt;
    logic [DATA_W-1:0]       alu_a, alu_b, alu_result;
    logic [CTRL_W-1:0]       alu_ctrl;
    logic [SHAMT_W-1:0]      alu_shamt;
    logic                    alu_zero, alu_overflow;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [DATA_W-1:0]       rsp_result;
    logic                    rsp_zero, rsp_overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_rsp;
    int   exp_g [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    // Reference MainALU; zero reports a == b, which is what the branch compare consumes.
    function automatic logic [DATA_W+1:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                                  input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (c)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SLL: r = b << sh;
            ALU_SRL: r = b >> sh;
            ALU_SRA: r = $signed(b) >>> sh;
            ALU_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            default: r = '0;
        endcase
        return {r, (a == b), ov};
    endfunction

    assign {alu_result, alu_zero, alu_overflow} = alu_ref(alu_ctrl, alu_a, alu_b, alu_shamt);

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ctrl     (req_ctrl),
        .req_shamt    (req_shamt),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_shamt    (alu_shamt),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        req_a[i*DATA_W +: DATA_W]      = a;
        req_b[i*DATA_W +: DATA_W]      = b;
        req_ctrl[i*CTRL_W +: CTRL_W]   = c;
        req_shamt[i*SHAMT_W +: SHAMT_W] = sh;
    endtask

    // Monitors handshakes for the coming edge, then advances to the next falling edge.
    task automatic cycle();
        exp_t            e;
        logic [NREQ-1:0] oh;
        #1;
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id = IDW'(i);
                {e.result, e.zero, e.ovf} = alu_ref(req_ctrl[i*CTRL_W +: CTRL_W],
                    req_a[i*DATA_W +: DATA_W], req_b[i*DATA_W +: DATA_W],
                    req_shamt[i*SHAMT_W +: SHAMT_W]);
                sb.push_back(e);
            end
        end
        if (rsp_valid != '0 && rsp_ready[rsp_id]) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e  = sb.pop_front();
                oh = NREQ'(1) << e.id;
                chk("rsp", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow},
                    {oh, e.id, e.result, e.zero, e.ovf});
                last_rsp = {rsp_id, rsp_result, rsp_zero, rsp_overflow};
                $display("rsp id=%0d result=0x%08h zero=%0b ovf=%0b", rsp_id, rsp_result,
                         rsp_zero, rsp_overflow);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input int id, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        set_req(id, c, a, b, sh);
        req_valid = NREQ'(1) << id;
        #1;
        chk("op_ready", 64'(req_ready), 64'(NREQ'(1) << id));
        cycle();
        req_valid = '0;
        #1;
        chk("op_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("op_alu_ctrl", 64'(alu_ctrl), 64'(c));
        cycle();
        #1;
        chk("op_rsp_valid", 64'(rsp_valid), 64'(NREQ'(1) << id));
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        req_shamt = '0;
        rsp_ready = '1;
        last_rsp  = '0;

        // Reset state, with requests pending
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(ALU_IDLE));
        chk("rst_alu_ops", {alu_a, alu_b}, 64'd0);
        chk("rst_alu_shamt", 64'(alu_shamt), 64'd0);
        chk("rst_rsp_fields", {rsp_id, rsp_result, rsp_zero, rsp_overflow}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;

        // Round-robin with all requesters valid, then a lone requester 2
        set_req(0, ALU_ADD, $urandom, $urandom, 5'd0);
        set_req(1, ALU_SUB, $urandom, $urandom, 5'd0);
        set_req(2, ALU_XOR, $urandom, $urandom, 5'd0);
        set_req(3, ALU_OR,  $urandom, $urandom, 5'd0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(NREQ'(1) << exp_g[k]));
            cycle();
        end
        req_valid = 4'b0100;
        #1;
        chk("rr_lone_2", 64'(req_ready), 64'b0100);
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Single request: ADD 5+7 from requester 0
        do_op(0, ALU_ADD, 32'd5, 32'd7, 5'd0);
        chk("single_add", 64'(last_rsp), 64'({2'd0, 32'd12, 1'b0, 1'b0}));
        #1;
        chk("idle_alu_ctrl", 64'(alu_ctrl), 64'(ALU_IDLE));

        // Backpressure: two accepts, then a three-cycle response stall
        set_req(0, ALU_ADD, 32'd1, 32'd2, 5'd0);
        set_req(1, ALU_SUB, 32'd100, 32'd30, 5'd0);
        set_req(2, ALU_XOR, 32'hF0, 32'hFF, 5'd0);
        rsp_ready = '0;
        req_valid = 4'b0011;
        #1;
        chk("bp_grant_1", 64'(req_ready), 64'b0010);
        cycle();
        #1;
        chk("bp_grant_0", 64'(req_ready), 64'b0001);
        cycle();
        req_valid = 4'b0100;
        repeat (3) begin
            #1;
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
            chk("bp_rsp_result", 64'(rsp_result), 64'd70);
            chk("bp_alu_held", {alu_a, 28'd0, alu_ctrl}, {32'd1, 28'd0, ALU_ADD});
            cycle();
        end
        rsp_ready = '1;
        #1;
        chk("bp_rel_rsp1", 64'(rsp_valid), 64'b0010);
        chk("bp_rel_ready2", 64'(req_ready), 64'b0100);
        cycle();
        req_valid = '0;
        #1;
        chk("bp_rel_rsp0", {rsp_valid, rsp_result}, {4'b0001, 32'd3});
        cycle();
        #1;
        chk("bp_rel_rsp2", {rsp_valid, rsp_result}, {4'b0100, 32'h0F});
        cycle();

        // Overflow, SLT, shift, zero flag and an undefined code
        do_op(3, ALU_ADD, 32'h7FFFFFFF, 32'd1, 5'd0);
        chk("add_ovf", 64'({last_rsp.result, last_rsp.ovf}), 64'({32'h80000000, 1'b1}));
        do_op(3, ALU_SUB, 32'h80000000, 32'd1, 5'd0);
        chk("sub_ovf", 64'({last_rsp.result, last_rsp.ovf}), 64'({32'h7FFFFFFF, 1'b1}));
        do_op(3, ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd0);
        chk("slt", 64'(last_rsp.result), 64'd1);
        do_op(3, ALU_SRA, 32'd0, 32'hF0000000, 5'd4);
        chk("sra", 64'(last_rsp.result), 64'hFF000000);
        do_op(3, ALU_AND, 32'h55, 32'h55, 5'd0);
        chk("and_zero", 64'({last_rsp.result, last_rsp.zero}), 64'({32'h55, 1'b1}));
        do_op(3, 4'b1000, 32'd3, 32'd4, 5'd0);
        chk("undef_code", 64'({last_rsp.result, last_rsp.ovf}), 64'd0);

        // Reset with both stages occupied
        set_req(0, ALU_ADD, 32'd10, 32'd20, 5'd0);
        set_req(1, ALU_OR, 32'h1, 32'h2, 5'd0);
        rsp_ready = '0;
        req_valid = 4'b0011;
        #1;
        chk("mr_grant_0", 64'(req_ready), 64'b0001);
        cycle();
        #1;
        chk("mr_grant_1", 64'(req_ready), 64'b0010);
        cycle();
        #1;
        chk("mr_pre_rsp", 64'(rsp_valid), 64'b0001);
        rst       = 1'b1;
        req_valid = 4'b0110;
        rsp_ready = '1;
        sb.delete();
        #1;
        chk("mr_req_ready", 64'(req_ready), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_alu", {alu_a, 28'd0, alu_ctrl}, {32'd0, 28'd0, ALU_IDLE});
        chk("mr_rsp_fields", {rsp_id, rsp_result, rsp_zero, rsp_overflow}, 64'd0);
        cycle();
        rst = 1'b0;
        #1;
        chk("mr_post_grant", 64'(req_ready), 64'b0010);
        chk("mr_post_rsp", 64'(rsp_valid), 64'd0);
        cycle();
        req_valid = '0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) cycle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
